// File: rtl/vmu_st_eng_pk.sv
// rtl/vmu_st_eng_pk.sv - vector store engine: vreg snapshot, early unlock, packed unit-strided and per-element strided requests
module vmu_st_eng_pk #(
    parameter int VECTOR_REGISTERS = 32,
    parameter int VECTOR_LANES     = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int REQ_DATA_WIDTH   = 64,
    localparam int RW  = $clog2(VECTOR_REGISTERS),
    localparam int VLW = $clog2(VECTOR_REGISTERS * VECTOR_LANES) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_in,
    output logic                                 ready_o,
    input  logic                                 instr_reconf_i,
    input  logic [1:0]                           instr_op_i,
    input  logic [RW-1:0]                        instr_src_i,
    input  logic [VLW-1:0]                       instr_vl_i,
    input  logic [VLW-1:0]                       instr_maxvl_i,
    input  logic [ADDR_WIDTH-1:0]                instr_base_i,
    input  logic [ADDR_WIDTH-1:0]                instr_stride_i,
    output logic [RW-1:0]                        rd_addr_1_o,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   rd_data_1_i,
    output logic                                 unlock_en_o,
    output logic [RW-1:0]                        unlock_reg_a_o,
    output logic                                 req_valid_o,
    input  logic                                 grant_i,
    output logic [ADDR_WIDTH-1:0]                req_addr_o,
    output logic [REQ_DATA_WIDTH-1:0]            req_data_o,
    output logic [REQ_DATA_WIDTH/8-1:0]          req_be_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic                                 is_busy_o
);
    localparam int EPR = REQ_DATA_WIDTH / DATA_WIDTH;
    localparam int BEW = REQ_DATA_WIDTH / 8;
    localparam int EB  = DATA_WIDTH / 8;
    localparam int LW  = $clog2(VECTOR_LANES);
    localparam int CW  = LW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;
    state_t state, state_nx;

    logic                  strided_q;
    logic [RW-1:0]         cur_q;
    logic [VLW-1:0]        vl_q, loop_q, max_exp_q;
    logic [ADDR_WIDTH-1:0] addr_q, stride_q;
    logic [DATA_WIDTH-1:0] buf_q [VECTOR_LANES];
    logic [CW-1:0]         cnt_q, ptr_q;
    logic                  done_q, err_q;

    logic [VLW-1:0] rem, loop_nx, maxvl_sh;
    logic [CW-1:0]  cnt_ld, left, beat_k;
    logic           last_beat, more_regs, accept_op, fire;

    // Elements still owed to the current vreg, clipped to one vreg's worth.
    assign rem       = vl_q - (loop_q << LW);
    assign cnt_ld    = (rem > VLW'(VECTOR_LANES)) ? CW'(VECTOR_LANES) : rem[CW-1:0];
    assign left      = cnt_q - ptr_q;
    assign beat_k    = strided_q ? CW'(1) : ((left > CW'(EPR)) ? CW'(EPR) : left);
    assign last_beat = (ptr_q + beat_k) >= cnt_q;
    assign loop_nx   = loop_q + VLW'(1);
    assign more_regs = (loop_nx < max_exp_q) && ((loop_nx << LW) < vl_q);
    assign maxvl_sh  = instr_maxvl_i >> LW;
    assign accept_op = (state == IDLE) && valid_in && !instr_reconf_i;
    assign fire      = (state == ISSUE) && grant_i;

    assign ready_o   = (state == IDLE);
    assign is_busy_o = (state != IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        rd_addr_1_o    = '0;
        unlock_en_o    = 1'b0;
        unlock_reg_a_o = '0;
        req_valid_o    = 1'b0;
        req_addr_o     = '0;
        req_data_o     = '0;
        req_be_o       = '0;
        case (state)
            IDLE: begin
                if (accept_op && instr_vl_i != '0 && !instr_op_i[0]) state_nx = LOAD;
            end
            LOAD: begin
                rd_addr_1_o    = cur_q;
                unlock_en_o    = 1'b1;
                unlock_reg_a_o = cur_q;
                state_nx       = ISSUE;
            end
            ISSUE: begin
                req_valid_o = 1'b1;
                req_addr_o  = addr_q;
                for (int s = 0; s < EPR; s++) begin
                    if (s < int'(beat_k))
                        req_data_o[s*DATA_WIDTH +: DATA_WIDTH] = buf_q[LW'(ptr_q + CW'(s))];
                end
                for (int b = 0; b < BEW; b++) req_be_o[b] = (b < int'(beat_k) * EB);
                if (grant_i && last_beat) state_nx = more_regs ? LOAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strided_q <= 1'b0;
            cur_q     <= '0;
            vl_q      <= '0;
            loop_q    <= '0;
            max_exp_q <= VLW'(1);
            addr_q    <= '0;
            stride_q  <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < VECTOR_LANES; i++) buf_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state == IDLE && valid_in && instr_reconf_i)
                max_exp_q <= (maxvl_sh == '0) ? VLW'(1) : maxvl_sh;
            if (accept_op) begin
                strided_q <= instr_op_i[1];
                cur_q     <= instr_src_i;
                vl_q      <= instr_vl_i;
                addr_q    <= instr_base_i;
                stride_q  <= instr_stride_i;
                loop_q    <= '0;
                // Empty or illegal instructions retire straight from IDLE.
                if (instr_vl_i == '0 || instr_op_i[0]) begin
                    done_q <= 1'b1;
                    err_q  <= instr_op_i[0];
                end
            end
            if (state == LOAD) begin
                for (int i = 0; i < VECTOR_LANES; i++)
                    buf_q[i] <= rd_data_1_i[i*DATA_WIDTH +: DATA_WIDTH];
                cnt_q <= cnt_ld;
                ptr_q <= '0;
            end
            if (fire) begin
                ptr_q  <= ptr_q + beat_k;
                addr_q <= addr_q + (strided_q ? stride_q : ADDR_WIDTH'(beat_k) * ADDR_WIDTH'(EB));
                if (last_beat) begin
                    if (more_regs) begin
                        loop_q <= loop_nx;
                        cur_q  <= cur_q + RW'(1);
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vmu_st_eng_pk.sv
// tb/tb_vmu_st_eng_pk.sv - randomized self-checking bench for vmu_st_eng_pk against a queue-based model
module tb_vmu_st_eng_pk;
    logic         clk, rst_n, valid_in, instr_reconf_i, grant_i;
    logic [1:0]   instr_op_i;
    logic [4:0]   instr_src_i, rd_addr_1_o, unlock_reg_a_o;
    logic [8:0]   instr_vl_i, instr_maxvl_i;
    logic [31:0]  instr_base_i, instr_stride_i, req_addr_o;
    logic [255:0] rd_data_1_i;
    logic         ready_o, unlock_en_o, req_valid_o, done_o, err_o, is_busy_o;
    logic [63:0]  req_data_o;
    logic [7:0]   req_be_o;

    logic [255:0] rf [32];
    int           total, bad, max_exp_m;
    logic [103:0] exp_b[$], obs_b[$];
    logic [4:0]   exp_u[$], obs_u[$];
    int           first_unlock, first_req, last_grant, done_cyc, unstable, post_done, nreg_m;
    logic         err_seen;

    vmu_st_eng_pk dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_o(ready_o),
        .instr_reconf_i(instr_reconf_i), .instr_op_i(instr_op_i), .instr_src_i(instr_src_i),
        .instr_vl_i(instr_vl_i), .instr_maxvl_i(instr_maxvl_i), .instr_base_i(instr_base_i),
        .instr_stride_i(instr_stride_i), .rd_addr_1_o(rd_addr_1_o), .rd_data_1_i(rd_data_1_i),
        .unlock_en_o(unlock_en_o), .unlock_reg_a_o(unlock_reg_a_o), .req_valid_o(req_valid_o),
        .grant_i(grant_i), .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_be_o(req_be_o),
        .done_o(done_o), .err_o(err_o), .is_busy_o(is_busy_o)
    );

    assign rd_data_1_i = rf[rd_addr_1_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand_vreg();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected request stream: element e of the instruction lives in vreg src+e/8, lane e%8.
    task automatic model(input logic [1:0] op, input int src, input int vl,
                         input logic [31:0] base, input logic [31:0] stride);
        int n, cnt, k, v, e;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        exp_b.delete(); exp_u.delete(); nreg_m = 0;
        if (vl == 0 || op[0]) return;
        nreg_m = (vl + 7) / 8;
        if (nreg_m > max_exp_m) nreg_m = max_exp_m;
        n = (vl < nreg_m * 8) ? vl : nreg_m * 8;
        for (int r = 0; r < nreg_m; r++) begin
            v = (src + r) % 32;
            exp_u.push_back(5'(v));
            cnt = (n - r * 8 > 8) ? 8 : n - r * 8;
            if (!op[1]) begin
                for (int p = 0; p < cnt; p += 2) begin
                    k  = (cnt - p >= 2) ? 2 : 1;
                    a  = base + 32'(4 * (r * 8 + p));
                    d  = {32'h0, rf[v][p*32 +: 32]};
                    if (k == 2) d[63:32] = rf[v][(p+1)*32 +: 32];
                    be = (k == 2) ? 8'hFF : 8'h0F;
                    exp_b.push_back({a, d, be});
                end
            end else begin
                for (int p = 0; p < cnt; p++) begin
                    e = r * 8 + p;
                    a = base + stride * 32'(e);
                    exp_b.push_back({a, 32'h0, rf[v][p*32 +: 32], 8'h0F});
                end
            end
        end
    endtask

    // Drives one instruction and records what the engine does until done_o (bounded).
    task automatic exec(input logic [1:0] op, input int src, input int vl,
                        input logic [31:0] base, input logic [31:0] stride, input int pct);
        logic         pend, scr_pend, g;
        logic [103:0] pend_v;
        logic [4:0]   scr_reg;
        obs_b.delete(); obs_u.delete();
        first_unlock = -1; first_req = -1; last_grant = -1; done_cyc = -1;
        unstable = 0; post_done = 0; err_seen = 1'b0; pend = 1'b0; scr_pend = 1'b0;
        pend_v = '0; scr_reg = '0;
        @(negedge clk);
        valid_in = 1'b1; instr_reconf_i = 1'b0; instr_op_i = op; instr_src_i = 5'(src);
        instr_vl_i = 9'(vl); instr_base_i = base; instr_stride_i = stride; instr_maxvl_i = 9'($urandom);
        for (int cyc = 1; cyc <= 1000 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            valid_in = 1'b0; grant_i = 1'b0;
            if (scr_pend) begin rf[scr_reg] = rand_vreg(); scr_pend = 1'b0; end
            @(negedge clk);
            if (unlock_en_o) begin
                obs_u.push_back(unlock_reg_a_o);
                if (first_unlock < 0) first_unlock = cyc;
                scr_pend = 1'b1; scr_reg = unlock_reg_a_o;
            end
            g = ($urandom_range(0, 99) < pct);
            grant_i = g;
            if (req_valid_o) begin
                if (first_req < 0) first_req = cyc;
                if (pend && {req_addr_o, req_data_o, req_be_o} !== pend_v) unstable++;
                if (g) begin
                    obs_b.push_back({req_addr_o, req_data_o, req_be_o});
                    last_grant = cyc; pend = 1'b0;
                end else begin
                    pend = 1'b1; pend_v = {req_addr_o, req_data_o, req_be_o};
                end
            end
            if (err_o) err_seen = 1'b1;
            if (done_o) done_cyc = cyc;
            if (!ready_o) begin
                valid_in = 1'($urandom_range(0, 1)); instr_reconf_i = 1'($urandom_range(0, 1));
                instr_op_i = 2'($urandom); instr_src_i = 5'($urandom); instr_vl_i = 9'($urandom);
                instr_maxvl_i = 9'($urandom); instr_base_i = $urandom; instr_stride_i = $urandom;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0; grant_i = 1'b0;
        @(negedge clk);
        post_done = int'(done_o) + int'(err_o) + int'(unlock_en_o) + int'(req_valid_o);
    endtask

    task automatic test_instr(input string name, input logic [1:0] op, input int src, input int vl,
                              input logic [31:0] base, input logic [31:0] stride, input int pct);
        logic legal;
        int   exp_done, m;
        legal = (vl != 0) && !op[0];
        model(op, src, vl, base, stride);
        exec(op, src, vl, base, stride, pct);
        total++;
        if (obs_b.size() != exp_b.size()) begin
            bad++; $display("FAIL %s beat_count got=%0d exp=%0d", name, obs_b.size(), exp_b.size());
        end
        m = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
        for (int i = 0; i < m; i++) begin
            total++;
            if (obs_b[i] !== exp_b[i]) begin
                bad++; $display("FAIL %s beat%0d addr/data/be got=%h exp=%h", name, i, obs_b[i], exp_b[i]);
            end
        end
        total++;
        if (obs_u != exp_u) begin
            bad++; $display("FAIL %s unlock_list got=%p exp=%p", name, obs_u, exp_u);
        end
        exp_done = legal ? ((last_grant < 0) ? -2 : last_grant + 1) : 1;
        total++;
        if (done_cyc !== exp_done) begin
            bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, exp_done);
        end
        total++;
        if (err_seen !== op[0]) begin
            bad++; $display("FAIL %s err got=%b exp=%b", name, err_seen, op[0]);
        end
        if (legal) begin
            total++;
            if (first_unlock !== 1 || first_req !== 2) begin
                bad++; $display("FAIL %s latency unlock/req got=%0d/%0d exp=1/2", name, first_unlock, first_req);
            end
            if (pct == 100) begin
                total++;
                if (last_grant !== exp_b.size() + nreg_m) begin
                    bad++; $display("FAIL %s back_to_back last_grant got=%0d exp=%0d", name, last_grant, exp_b.size() + nreg_m);
                end
            end
        end
        total++;
        if (unstable !== 0 || post_done !== 0) begin
            bad++; $display("FAIL %s stall_hold/after_done got=%0d/%0d exp=0/0", name, unstable, post_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ready_o, is_busy_o, req_valid_o, unlock_en_o, done_o, err_o, req_be_o} !== {1'b1, 13'b0}) begin
            bad++; $display("FAIL reset outputs got=%b exp=%b",
                {ready_o, is_busy_o, req_valid_o, unlock_en_o, done_o, err_o, req_be_o}, {1'b1, 13'b0});
        end
        rst_n = 1'b1; max_exp_m = 1;
    endtask

    task automatic test_reconf(input int maxvl);
        @(negedge clk);
        valid_in = 1'b1; instr_reconf_i = 1'b1; instr_maxvl_i = 9'(maxvl); instr_vl_i = 9'd8;
        @(posedge clk); #1;
        valid_in = 1'b0; instr_reconf_i = 1'b0;
        max_exp_m = (maxvl / 8 == 0) ? 1 : maxvl / 8;
        @(negedge clk);
        total++;
        if ({ready_o, done_o, unlock_en_o} !== 3'b100) begin
            bad++; $display("FAIL reconf stays_idle got=%b exp=100", {ready_o, done_o, unlock_en_o});
        end
    endtask

    task automatic test_spec_cases();
        test_instr("unit_vl8", 2'b00, 4, 8, 32'h1000, 32'h0, 100);
        test_instr("unit_vl5", 2'b00, 7, 5, 32'h2000, 32'h0, 100);
        test_instr("strided_pos", 2'b10, 2, 3, 32'h100, 32'h40, 100);
        test_instr("strided_neg", 2'b10, 2, 3, 32'h100, 32'hFFFF_FFC0, 100);
        test_reconf(32);
        test_instr("multi_vreg", 2'b00, 8, 20, 32'h3000, 32'h0, 100);
        test_instr("wrap_vreg", 2'b10, 31, 12, 32'hFFFF_FFF8, 32'h4, 100);
        test_reconf(16);
        test_instr("maxexp_clip", 2'b00, 0, 20, 32'h4000, 32'h0, 100);
        test_reconf(3);
        test_instr("maxvl_small", 2'b00, 1, 16, 32'h5000, 32'h0, 100);
    endtask

    task automatic test_stall();
        test_reconf(64);
        test_instr("stall_unit", 2'b00, 5, 19, 32'h6000, 32'h0, 15);
        test_instr("stall_strided", 2'b10, 9, 10, 32'h7000, 32'h24, 15);
    endtask

    task automatic test_illegal();
        test_instr("vl_zero", 2'b00, 3, 0, 32'h100, 32'h0, 100);
        test_instr("op01", 2'b01, 3, 8, 32'h100, 32'h0, 100);
        test_instr("op11", 2'b11, 3, 8, 32'h100, 32'h0, 100);
    endtask

    task automatic test_reset_mid();
        int viol;
        test_reconf(32);
        @(negedge clk);
        valid_in = 1'b1; instr_reconf_i = 1'b0; instr_op_i = 2'b00; instr_src_i = 5'd3;
        instr_vl_i = 9'd24; instr_base_i = 32'h8000; instr_stride_i = 32'h0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int i = 0; i < 10 && !req_valid_o; i++) @(negedge clk);
        total++;
        if (req_valid_o !== 1'b1) begin
            bad++; $display("FAIL reset_mid reach_issue got=%b exp=1", req_valid_o);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; max_exp_m = 1;
        @(negedge clk);
        total++;
        if ({req_valid_o, ready_o} !== 2'b01) begin
            bad++; $display("FAIL reset_mid abort got=%b exp=01", {req_valid_o, ready_o});
        end
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o || err_o || unlock_en_o || req_valid_o) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL reset_mid quiet got=%0d exp=0", viol);
        end
        test_instr("after_reset_maxexp", 2'b00, 6, 16, 32'h9000, 32'h0, 100);
    endtask

    task automatic test_random();
        int r, vl, pct;
        logic [1:0] op;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 4) == 0) test_reconf($urandom_range(0, 256));
            r   = $urandom_range(0, 9);
            op  = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r < 6) ? 2'b00 : 2'b10;
            vl  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 48);
            pct = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(25, 90);
            test_instr("random", op, $urandom_range(0, 31), vl, $urandom, $urandom, pct);
        end
    endtask

    initial begin
        total = 0; bad = 0; max_exp_m = 1;
        rst_n = 1'b0; valid_in = 1'b0; instr_reconf_i = 1'b0; instr_op_i = '0; instr_src_i = '0;
        instr_vl_i = '0; instr_maxvl_i = '0; instr_base_i = '0; instr_stride_i = '0; grant_i = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = rand_vreg();
        test_reset();
        test_spec_cases();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
